// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - requester A/B and SDRAM toggle-handshake bundle for the port arbiter
interface sdram_port_arbiter_if #(
    parameter int A_BITS = 24
);
    logic              a_req;
    logic              a_ack;
    logic              a_we;
    logic [A_BITS-1:0] a_a;
    logic [7:0]        a_d;
    logic [7:0]        a_q;

    logic              b_req;
    logic              b_ack;
    logic              b_we;
    logic [A_BITS-1:0] b_a;
    logic [7:0]        b_d;
    logic [7:0]        b_q;

    logic              ram_req;
    logic              ram_ack;
    logic              ram_we;
    logic [A_BITS-1:0] ram_a;
    logic [7:0]        ram_d;
    logic [7:0]        ram_q;

    modport slave (
        input  a_req, a_we, a_a, a_d,
        output a_ack, a_q,
        input  b_req, b_we, b_a, b_d,
        output b_ack, b_q,
        output ram_req, ram_we, ram_a, ram_d,
        input  ram_ack, ram_q
    );

    modport master (
        output a_req, a_we, a_a, a_d,
        input  a_ack, a_q,
        output b_req, b_we, b_a, b_d,
        input  b_ack, b_q,
        input  ram_req, ram_we, ram_a, ram_d,
        output ram_ack, ram_q
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-requester toggle-handshake arbiter onto one SDRAM byte port
module sdram_port_arbiter #(
    parameter int A_BITS     = 24,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    sdram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {SYNC, IDLE, BUSY_A, BUSY_B} state_t;

    state_t            r_state,   w_state_nx;
    logic              r_a_ack,   w_a_ack_nx;
    logic              r_b_ack,   w_b_ack_nx;
    logic [7:0]        r_a_q,     w_a_q_nx;
    logic [7:0]        r_b_q,     w_b_q_nx;
    logic              r_ram_req, w_ram_req_nx;
    logic              r_ram_we,  w_ram_we_nx;
    logic [A_BITS-1:0] r_ram_a,   w_ram_a_nx;
    logic [7:0]        r_ram_d,   w_ram_d_nx;
    logic              r_last_b,  w_last_b_nx;

    logic w_pend_a;
    logic w_pend_b;
    logic w_done;
    logic w_pick_a;

    assign w_pend_a = bus.a_req ^ r_a_ack;
    assign w_pend_b = bus.b_req ^ r_b_ack;
    assign w_done   = (bus.ram_ack == r_ram_req);
    // A wins a tie under fixed priority, or when B was the most recent grant
    assign w_pick_a = w_pend_a && (!w_pend_b || FIXED_PRIO || r_last_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= SYNC;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_q     <= 8'h00;
            r_b_q     <= 8'h00;
            r_ram_req <= 1'b0;
            r_ram_we  <= 1'b0;
            r_ram_a   <= '0;
            r_ram_d   <= 8'h00;
            r_last_b  <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_a_ack   <= w_a_ack_nx;
            r_b_ack   <= w_b_ack_nx;
            r_a_q     <= w_a_q_nx;
            r_b_q     <= w_b_q_nx;
            r_ram_req <= w_ram_req_nx;
            r_ram_we  <= w_ram_we_nx;
            r_ram_a   <= w_ram_a_nx;
            r_ram_d   <= w_ram_d_nx;
            r_last_b  <= w_last_b_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_a_ack_nx   = r_a_ack;
        w_b_ack_nx   = r_b_ack;
        w_a_q_nx     = r_a_q;
        w_b_q_nx     = r_b_q;
        w_ram_req_nx = r_ram_req;
        w_ram_we_nx  = r_ram_we;
        w_ram_a_nx   = r_ram_a;
        w_ram_d_nx   = r_ram_d;
        w_last_b_nx  = r_last_b;

        case (r_state)
            // SDRAM may still be finishing a transaction started before our reset
            SYNC: begin
                if (w_done) begin
                    w_state_nx = IDLE;
                end
            end
            IDLE: begin
                if (w_pick_a) begin
                    w_ram_we_nx  = bus.a_we;
                    w_ram_a_nx   = bus.a_a;
                    w_ram_d_nx   = bus.a_d;
                    w_ram_req_nx = ~r_ram_req;
                    w_last_b_nx  = 1'b0;
                    w_state_nx   = BUSY_A;
                end else if (w_pend_b) begin
                    w_ram_we_nx  = bus.b_we;
                    w_ram_a_nx   = bus.b_a;
                    w_ram_d_nx   = bus.b_d;
                    w_ram_req_nx = ~r_ram_req;
                    w_last_b_nx  = 1'b1;
                    w_state_nx   = BUSY_B;
                end
            end
            BUSY_A: begin
                if (w_done) begin
                    if (!r_ram_we) begin
                        w_a_q_nx = bus.ram_q;
                    end
                    w_a_ack_nx = ~r_a_ack;
                    w_state_nx = IDLE;
                end
            end
            BUSY_B: begin
                if (w_done) begin
                    if (!r_ram_we) begin
                        w_b_q_nx = bus.ram_q;
                    end
                    w_b_ack_nx = ~r_b_ack;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = SYNC;
        endcase
    end

    assign bus.a_ack   = r_a_ack;
    assign bus.b_ack   = r_b_ack;
    assign bus.a_q     = r_a_q;
    assign bus.b_q     = r_b_q;
    assign bus.ram_req = r_ram_req;
    assign bus.ram_we  = r_ram_we;
    assign bus.ram_a   = r_ram_a;
    assign bus.ram_d   = r_ram_d;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - randomized self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.A_BITS(24)) bus0 ();
    sdram_port_arbiter_if #(.A_BITS(24)) bus1 ();

    sdram_port_arbiter #(.A_BITS(24), .FIXED_PRIO(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    sdram_port_arbiter #(.A_BITS(24), .FIXED_PRIO(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    // SDRAM content that was never written
    function automatic logic [7:0] init_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    logic [7:0]  mem0 [logic [23:0]];
    logic [7:0]  mem1 [logic [23:0]];
    logic [23:0] log0 [$];
    logic [23:0] log1 [$];
    bit          m0_busy = 0, m1_busy = 0, m0_skip = 0;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [23:0] m0_a, m1_a;
    logic [7:0]  m0_d, m1_d;
    int          m0_cnt, m1_cnt, m0_issued = 0, m0_viol = 0, m1_viol = 0;
    int          m0_dmin = 1, m0_dmax = 4, m1_dmin = 1, m1_dmax = 3;
    int          req_cnt_a = 0, req_cnt_b = 0, ack_cnt_a = 0, ack_cnt_b = 0;
    logic        mon_a_prev = 1'b0, mon_b_prev = 1'b0;

    // SDRAM behavioural model for the round-robin instance
    always @(negedge clk) begin
        if (reset && m0_busy) m0_skip = 1'b1;
        if (!m0_busy) begin
            if (bus0.ram_req !== bus0.ram_ack) begin
                m0_busy = 1; m0_req = bus0.ram_req; m0_we = bus0.ram_we;
                m0_a = bus0.ram_a; m0_d = bus0.ram_d;
                m0_cnt = $urandom_range(m0_dmax, m0_dmin);
                m0_issued++;
                log0.push_back(bus0.ram_a);
            end
        end else begin
            if (!m0_skip && (bus0.ram_req !== m0_req || bus0.ram_we !== m0_we ||
                             bus0.ram_a !== m0_a || bus0.ram_d !== m0_d)) m0_viol++;
            m0_cnt--;
            if (m0_cnt == 0) begin
                if (m0_we) mem0[m0_a] = m0_d;
                else bus0.ram_q = mem0.exists(m0_a) ? mem0[m0_a] : init_byte(m0_a);
                bus0.ram_ack = bus0.ram_req;
                m0_busy = 0; m0_skip = 0;
            end
        end
    end

    // SDRAM behavioural model for the fixed-priority instance
    always @(negedge clk) begin
        if (!m1_busy) begin
            if (bus1.ram_req !== bus1.ram_ack) begin
                m1_busy = 1; m1_req = bus1.ram_req; m1_we = bus1.ram_we;
                m1_a = bus1.ram_a; m1_d = bus1.ram_d;
                m1_cnt = $urandom_range(m1_dmax, m1_dmin);
                log1.push_back(bus1.ram_a);
            end
        end else begin
            if (bus1.ram_req !== m1_req || bus1.ram_a !== m1_a || bus1.ram_d !== m1_d) m1_viol++;
            m1_cnt--;
            if (m1_cnt == 0) begin
                if (m1_we) mem1[m1_a] = m1_d;
                else bus1.ram_q = mem1.exists(m1_a) ? mem1[m1_a] : init_byte(m1_a);
                bus1.ram_ack = bus1.ram_req;
                m1_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus0.a_ack !== mon_a_prev) ack_cnt_a++;
            if (bus0.b_ack !== mon_b_prev) ack_cnt_b++;
        end
        mon_a_prev = bus0.a_ack;
        mon_b_prev = bus0.b_ack;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus0.a_req = 0; bus0.b_req = 0; bus1.a_req = 0; bus1.b_req = 0;
        bus0.ram_ack = 0; bus1.ram_ack = 0;
        m0_busy = 0; m1_busy = 0; m0_skip = 0;
        log0.delete(); log1.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic port_op(input bit pb, input logic we, input logic [23:0] addr,
                           input logic [7:0] d, output logic [7:0] q);
        bit ok = 0;
        @(posedge clk); #1;
        if (!pb) begin
            bus0.a_we = we; bus0.a_a = addr; bus0.a_d = d; bus0.a_req = ~bus0.a_req; req_cnt_a++;
        end else begin
            bus0.b_we = we; bus0.b_a = addr; bus0.b_d = d; bus0.b_req = ~bus0.b_req; req_cnt_b++;
        end
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (pb ? (bus0.b_ack === bus0.b_req) : (bus0.a_ack === bus0.a_req)) begin
                ok = 1; break;
            end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL op_timeout port=%0d: no ack within 400 cycles, ack required", pb);
        end
        q = pb ? bus0.b_q : bus0.a_q;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus0.a_ack, bus0.b_ack, bus0.a_q, bus0.b_q, bus0.ram_req, bus0.ram_we, bus0.ram_a, bus0.ram_d} !== '0) begin
            n_err++;
            $display("FAIL reset_rr: ack=%b%b aq=%h bq=%h req=%b we=%b a=%h d=%h, all zero required",
                     bus0.a_ack, bus0.b_ack, bus0.a_q, bus0.b_q, bus0.ram_req, bus0.ram_we, bus0.ram_a, bus0.ram_d);
        end
        n_cmp++;
        if ({bus1.a_ack, bus1.b_ack, bus1.ram_req, bus1.ram_a} !== '0) begin
            n_err++;
            $display("FAIL reset_fixed: ack=%b%b req=%b a=%h, all zero required",
                     bus1.a_ack, bus1.b_ack, bus1.ram_req, bus1.ram_a);
        end
    endtask

    task automatic test_single_read();
        logic prev_ack, prev_req, done;
        int   issued0;
        bit   seen = 0;
        mem0[24'h000123] = 8'h5A;
        m0_dmin = 3; m0_dmax = 3;
        @(posedge clk); #1;
        prev_ack = bus0.a_ack; prev_req = bus0.ram_req; issued0 = m0_issued;
        bus0.a_we = 0; bus0.a_a = 24'h000123; bus0.a_d = 8'h00; bus0.a_req = ~bus0.a_req; req_cnt_a++;
        @(posedge clk); #1;
        n_cmp++;
        if (bus0.ram_req !== ~prev_req || bus0.ram_a !== 24'h000123 || bus0.ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: req=%b a=%h we=%b, required req=%b a=000123 we=0",
                     bus0.ram_req, bus0.ram_a, bus0.ram_we, ~prev_req);
        end
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk); #1;
            done = (bus0.ram_ack === bus0.ram_req);
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                n_cmp++;
                if (bus0.a_ack !== ~prev_ack || bus0.a_q !== 8'h5A) begin
                    n_err++;
                    $display("FAIL single_done: ack=%b q=%h, required ack=%b q=5a", bus0.a_ack, bus0.a_q, ~prev_ack);
                end
                n_cmp++;
                if (m0_issued !== issued0 + 1) begin
                    n_err++;
                    $display("FAIL single_count: %0d sdram requests, 1 required", m0_issued - issued0);
                end
            end else if (bus0.a_ack !== prev_ack) begin
                n_cmp++; n_err++;
                $display("FAIL single_early_ack: ack=%b before completion, %b required", bus0.a_ack, prev_ack);
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL single_timeout: no completion, completion required");
        end
        m0_dmin = 1; m0_dmax = 4;
    endtask

    task automatic test_round_robin();
        int          pat;
        bit          exp_last_b, ok;
        logic [23:0] exp_q [$];
        do_reset();
        exp_last_b = 1;
        for (int r = 0; r < 8; r++) begin
            pat = (r == 0) ? 3 : int'($urandom_range(3, 1));
            log0.delete(); exp_q.delete();
            @(posedge clk); #1;
            if (pat[0]) begin
                bus0.a_we = 0; bus0.a_a = 24'h0000A0 + 24'(r); bus0.a_req = ~bus0.a_req; req_cnt_a++;
            end
            if (pat[1]) begin
                bus0.b_we = 0; bus0.b_a = 24'h0000B0 + 24'(r); bus0.b_req = ~bus0.b_req; req_cnt_b++;
            end
            if (pat == 3) begin
                if (exp_last_b) begin
                    exp_q.push_back(24'h0000A0 + 24'(r)); exp_q.push_back(24'h0000B0 + 24'(r)); exp_last_b = 1;
                end else begin
                    exp_q.push_back(24'h0000B0 + 24'(r)); exp_q.push_back(24'h0000A0 + 24'(r)); exp_last_b = 0;
                end
            end else if (pat == 1) begin
                exp_q.push_back(24'h0000A0 + 24'(r)); exp_last_b = 0;
            end else begin
                exp_q.push_back(24'h0000B0 + 24'(r)); exp_last_b = 1;
            end
            ok = 0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk); #1;
                if (bus0.a_ack === bus0.a_req && bus0.b_ack === bus0.b_req) begin ok = 1; break; end
            end
            n_cmp++;
            if (!ok || log0.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL rr_round%0d: %0d grants (done=%0d), %0d required", r, log0.size(), ok, exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    n_cmp++;
                    if (log0[k] !== exp_q[k]) begin
                        n_err++;
                        $display("FAIL rr_order r=%0d k=%0d: addr %h, %h required", r, k, log0[k], exp_q[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_fixed_prio();
        bit ok;
        logic [23:0] base = 24'h001000;
        log1.delete();
        @(posedge clk); #1;
        bus1.b_we = 1; bus1.b_a = 24'h300000; bus1.b_d = 8'h77; bus1.b_req = ~bus1.b_req;
        bus1.a_we = 1; bus1.a_a = base; bus1.a_d = 8'h00; bus1.a_req = ~bus1.a_req;
        for (int i = 0; i < 256; i++) begin
            ok = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (bus1.a_ack === bus1.a_req) begin ok = 1; break; end
            end
            if (!ok) begin
                n_cmp++; n_err++;
                $display("FAIL fixed_a_timeout i=%0d: no ack, ack required", i);
                break;
            end
            if (i < 255) begin
                bus1.a_a = base + 24'(i + 1); bus1.a_d = 8'(i + 1); bus1.a_req = ~bus1.a_req;
            end
        end
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (bus1.b_ack === bus1.b_req) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok || log1.size() != 257) begin
            n_err++;
            $display("FAIL fixed_count: %0d grants (b_done=%0d), 257 required", log1.size(), ok);
        end else begin
            n_cmp++;
            if (log1[256] !== 24'h300000) begin
                n_err++;
                $display("FAIL fixed_b_last: last grant %h, 300000 required", log1[256]);
            end
            for (int i = 0; i < 256; i++) begin
                n_cmp++;
                if (log1[i] !== base + 24'(i) || !mem1.exists(base + 24'(i)) || mem1[base + 24'(i)] !== 8'(i)) begin
                    n_err++;
                    $display("FAIL fixed_seq i=%0d: addr %h, %h required", i, log1[i], base + 24'(i));
                end
            end
        end
    endtask

    task automatic test_write_read_b();
        logic [7:0] q, aq;
        aq = bus0.a_q;
        port_op(1, 1, 24'hFFFFFF, 8'hC3, q);
        port_op(1, 0, 24'hFFFFFF, 8'h00, q);
        n_cmp++;
        if (q !== 8'hC3) begin
            n_err++; $display("FAIL b_readback: b_q=%h, c3 required", q);
        end
        n_cmp++;
        if (bus0.a_q !== aq) begin
            n_err++; $display("FAIL b_a_q_kept: a_q=%h, %h required", bus0.a_q, aq);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [7:0] q;
        bit ok;
        if (bus0.a_ack !== 1'b1) port_op(0, 0, 24'h000010, 8'h00, q);
        if (bus0.b_ack !== 1'b0) port_op(1, 0, 24'h000011, 8'h00, q);
        n_cmp++;
        if (bus0.ram_req !== 1'b1 || bus0.ram_ack !== 1'b1) begin
            n_err++;
            $display("FAIL mid_precond: req=%b ack=%b, 1/1 required", bus0.ram_req, bus0.ram_ack);
        end
        m0_dmin = 10; m0_dmax = 10;
        @(posedge clk); #1;
        bus0.a_we = 0; bus0.a_a = 24'h000200; bus0.a_req = ~bus0.a_req;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        bus0.a_req = 0; bus0.b_req = 0;
        #1;
        n_cmp++;
        if (bus0.a_ack !== 1'b0 || bus0.b_ack !== 1'b0 || bus0.ram_req !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_acks: a_ack=%b b_ack=%b req=%b, 0/0/0 required", bus0.a_ack, bus0.b_ack, bus0.ram_req);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bus0.b_we = 1; bus0.b_a = 24'h000300; bus0.b_d = 8'h99; bus0.b_req = ~bus0.b_req; req_cnt_b++;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (!m0_busy) break;
            n_cmp++;
            if (bus0.ram_req !== 1'b0) begin
                n_err++; $display("FAIL mid_sync_hold c=%0d: ram_req=%b while sdram busy, 0 required", c, bus0.ram_req);
            end
        end
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus0.b_ack === bus0.b_req) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok || bus0.b_ack !== 1'b1 || !mem0.exists(24'h000300) || mem0[24'h000300] !== 8'h99) begin
            n_err++;
            $display("FAIL mid_b_after_sync: b_ack=%b done=%0d, b_ack=1 and write landed required", bus0.b_ack, ok);
        end
        m0_dmin = 1; m0_dmax = 4;
    endtask

    task automatic test_random();
        logic [7:0] sh_a [logic [23:0]];
        logic [7:0] sh_b [logic [23:0]];
        m0_dmin = 1; m0_dmax = 20;
        fork
            begin
                logic [7:0] q, d, e; logic [23:0] ad; logic we;
                for (int i = 0; i < 1000; i++) begin
                    we = 1'($urandom); ad = 24'h400000 | 24'($urandom_range(63, 0)); d = 8'($urandom);
                    port_op(0, we, ad, d, q);
                    if (we) sh_a[ad] = d;
                    else begin
                        e = sh_a.exists(ad) ? sh_a[ad] : init_byte(ad);
                        n_cmp++;
                        if (q !== e) begin n_err++; $display("FAIL rand_a i=%0d addr=%h: q=%h, %h required", i, ad, q, e); end
                    end
                    repeat ($urandom_range(2, 0)) @(posedge clk);
                end
            end
            begin
                logic [7:0] q, d, e; logic [23:0] ad; logic we;
                for (int i = 0; i < 1000; i++) begin
                    we = 1'($urandom); ad = 24'h500000 | 24'($urandom_range(63, 0)); d = 8'($urandom);
                    port_op(1, we, ad, d, q);
                    if (we) sh_b[ad] = d;
                    else begin
                        e = sh_b.exists(ad) ? sh_b[ad] : init_byte(ad);
                        n_cmp++;
                        if (q !== e) begin n_err++; $display("FAIL rand_b i=%0d addr=%h: q=%h, %h required", i, ad, q, e); end
                    end
                    repeat ($urandom_range(2, 0)) @(posedge clk);
                end
            end
        join
    endtask

    task automatic test_ack_accounting();
        repeat (2) @(posedge clk);
        n_cmp++;
        if (ack_cnt_a !== req_cnt_a || ack_cnt_b !== req_cnt_b) begin
            n_err++;
            $display("FAIL ack_once: acks a=%0d b=%0d, required a=%0d b=%0d", ack_cnt_a, ack_cnt_b, req_cnt_a, req_cnt_b);
        end
        n_cmp++;
        if (m0_issued !== req_cnt_a + req_cnt_b + 1) begin
            n_err++;
            $display("FAIL sdram_issued: %0d transactions, %0d required", m0_issued, req_cnt_a + req_cnt_b + 1);
        end
        n_cmp++;
        if (m0_viol !== 0 || m1_viol !== 0) begin
            n_err++;
            $display("FAIL one_outstanding: ram outputs moved mid-transaction %0d/%0d times, 0 required", m0_viol, m1_viol);
        end
    endtask

    initial begin
        bus0.a_req = 0; bus0.a_we = 0; bus0.a_a = '0; bus0.a_d = '0;
        bus0.b_req = 0; bus0.b_we = 0; bus0.b_a = '0; bus0.b_d = '0;
        bus0.ram_ack = 0; bus0.ram_q = '0;
        bus1.a_req = 0; bus1.a_we = 0; bus1.a_a = '0; bus1.a_d = '0;
        bus1.b_req = 0; bus1.b_we = 0; bus1.b_a = '0; bus1.b_d = '0;
        bus1.ram_ack = 0; bus1.ram_q = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_write_read_b();
        test_reset_mid_busy();
        test_random();
        test_ack_accounting();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
